midi_rx_parser: RTL and testbench

- Front end of the synth: receives a raw 31250-baud MIDI serial stream and decodes channel-voice messages.
- Emits single-cycle note_pressed / note_released / note_keypress / note_channelpress strobes with note, velocity and channel.
- Outputs connect directly to the voice engine's event FIFO inputs.
- Handles running status, real-time bytes interleaved mid-message, and framing errors.

---
 rtl/midi_rx_parser.sv | 229 ++++++++++++++++++++++
 tb/tb_midi_rx_parser.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_rx_parser.sv
// MIDI receiver: 2-flop line synchroniser, oversampling UART and a channel-voice
// message parser with running status, emitting one-cycle note event strobes.
module midi_rx_parser #(
   parameter int CLKS_PER_BIT = 1024
) (
   input  logic       clk32,
   input  logic       rst_n,
   input  logic       midi_in,
   output logic       note_pressed,
   output logic       note_released,
   output logic       note_keypress,
   output logic       note_channelpress,
   output logic [6:0] note_interface,
   output logic [6:0] velocity,
   output logic [3:0] channel,
   output logic       framing_err
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CW       = $clog2(CLKS_PER_BIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } uart_state_t;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   logic [1:0]  sync_q;
   logic        line;
   uart_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_strobe_q, rx_strobe_d;
   logic        fe_q, fe_d;

   assign line = sync_q[1];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      rx_strobe_d = 1'b0;
      fe_d        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!line) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == CW'(HALF_BIT - 1)) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = line ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               shift_d = {line, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               if (line) begin
                  rx_strobe_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_HIGH: begin
            if (line) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Parser state: running status of 0 means none (bit 7 is the valid flag).
   logic [7:0] rs_q, rs_d;
   logic       have_key_q, have_key_d;
   logic [6:0] key_q, key_d;
   logic       pressed_q, pressed_d;
   logic       released_q, released_d;
   logic       keypress_q, keypress_d;
   logic       chanpress_q, chanpress_d;
   logic [6:0] note_q, note_d;
   logic [6:0] vel_q, vel_d;
   logic [3:0] ch_q, ch_d;
   logic       one_byte;
   logic       msg_done;
   logic [6:0] d1, d2;

   always_comb begin
      rs_d        = rs_q;
      have_key_d  = have_key_q;
      key_d       = key_q;
      pressed_d   = 1'b0;
      released_d  = 1'b0;
      keypress_d  = 1'b0;
      chanpress_d = 1'b0;
      note_d      = note_q;
      vel_d       = vel_q;
      ch_d        = ch_q;
      one_byte    = (rs_q[7:5] == 3'b110);
      msg_done    = 1'b0;
      d1          = 7'd0;
      d2          = 7'd0;

      if (fe_q) have_key_d = 1'b0;

      if (rx_strobe_q) begin
         if (shift_q >= 8'hF8) begin
            rs_d = rs_q;
         end else if (shift_q[7:4] == 4'hF) begin
            rs_d       = 8'h00;
            have_key_d = 1'b0;
         end else if (shift_q[7]) begin
            rs_d       = shift_q;
            have_key_d = 1'b0;
         end else if (rs_q[7]) begin
            if (one_byte || have_key_q) begin
               msg_done   = 1'b1;
               have_key_d = 1'b0;
               d1         = one_byte ? 7'd0 : key_q;
               d2         = shift_q[6:0];
            end else begin
               key_d      = shift_q[6:0];
               have_key_d = 1'b1;
            end
         end
      end

      if (msg_done) begin
         case (rs_q[7:4])
            4'h8: released_d  = 1'b1;
            4'h9: begin
               if (d2 != 7'd0) pressed_d  = 1'b1;
               else            released_d = 1'b1;
            end
            4'hA: keypress_d  = 1'b1;
            4'hD: chanpress_d = 1'b1;
            default: ;
         endcase
         if (rs_q[7:4] == 4'h8 || rs_q[7:4] == 4'h9 ||
             rs_q[7:4] == 4'hA || rs_q[7:4] == 4'hD) begin
            note_d = d1;
            vel_d  = d2;
            ch_d   = rs_q[3:0];
         end
      end
   end

   always_ff @(posedge clk32 or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync_q      <= 2'b11;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_strobe_q <= 1'b0;
         fe_q        <= 1'b0;
         rs_q        <= 8'h00;
         have_key_q  <= 1'b0;
         key_q       <= 7'd0;
         pressed_q   <= 1'b0;
         released_q  <= 1'b0;
         keypress_q  <= 1'b0;
         chanpress_q <= 1'b0;
         note_q      <= 7'd0;
         vel_q       <= 7'd0;
         ch_q        <= 4'd0;
      end else begin
         sync_q      <= {sync_q[0], midi_in};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_strobe_q <= rx_strobe_d;
         fe_q        <= fe_d;
         rs_q        <= rs_d;
         have_key_q  <= have_key_d;
         key_q       <= key_d;
         pressed_q   <= pressed_d;
         released_q  <= released_d;
         keypress_q  <= keypress_d;
         chanpress_q <= chanpress_d;
         note_q      <= note_d;
         vel_q       <= vel_d;
         ch_q        <= ch_d;
      end
   end

   assign note_pressed      = pressed_q;
   assign note_released     = released_q;
   assign note_keypress     = keypress_q;
   assign note_channelpress = chanpress_q;
   assign note_interface    = note_q;
   assign velocity          = vel_q;
   assign channel           = ch_q;
   assign framing_err       = fe_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: serial byte driver, event monitor, table vectors,
// corner-case sequences and a random byte stream checked against a message model.
module tb_midi_rx_parser;

   localparam int CPB = 16;
   localparam int LAT = 4 + 9 * CPB + CPB / 2;

   logic       clk32 = 1'b0;
   logic       rst_n = 1'b0;
   logic       midi_in = 1'b1;
   logic       note_pressed, note_released, note_keypress, note_channelpress;
   logic [6:0] note_interface, velocity;
   logic [3:0] channel;
   logic       framing_err;

   always #5 clk32 = ~clk32;

   midi_rx_parser #(.CLKS_PER_BIT(CPB)) dut (
      .clk32(clk32), .rst_n(rst_n), .midi_in(midi_in),
      .note_pressed(note_pressed), .note_released(note_released),
      .note_keypress(note_keypress), .note_channelpress(note_channelpress),
      .note_interface(note_interface), .velocity(velocity),
      .channel(channel), .framing_err(framing_err)
   );

   // kind: 1 pressed, 2 released, 3 keypress, 4 channel pressure
   typedef struct {
      int     kind;
      int     note;
      int     vel;
      int     ch;
      longint cyc;
   } ev_t;

   typedef struct {
      int          n;
      logic [47:0] bytes;
      int          ne;
      int k0, n0, v0, c0;
      int k1, n1, v1, c1;
   } vec_t;

   ev_t    act_q[$];
   ev_t    mdl_q[$];
   vec_t   vecs[$];
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   int     fe_cnt = 0;

   int mdl_rs = -1;
   int mdl_data[$];
   int last_note = 0, last_vel = 0, last_ch = 0;

   logic [3:0] strb, prev_strb = 4'b0;
   logic       prev_fe = 1'b0;
   ev_t        mon_e;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic lat_chk(input string name, input longint act_cyc, input longint exp_cyc);
      longint d;
      d = act_cyc - exp_cyc;
      checks++;
      if (d < -2 || d > 2) begin
         errors++;
         $display("FAIL %s: event at cycle %0d expected %0d (+-2)", name, act_cyc, exp_cyc);
      end
   endtask

   task automatic emit(input int kind, input int note, input int vel, input int ch, input longint c);
      ev_t e;
      e.kind = kind; e.note = note; e.vel = vel; e.ch = ch; e.cyc = c;
      mdl_q.push_back(e);
      last_note = note; last_vel = vel; last_ch = ch;
   endtask

   // Message-level model: status byte, collected data bytes, length by status nibble.
   task automatic model_byte(input int b, input longint fall);
      int hi, need, ch;
      longint t;
      if (b >= 'hF8) return;
      if (b >= 'hF0) begin mdl_rs = -1; mdl_data.delete(); return; end
      if (b >= 'h80) begin mdl_rs = b; mdl_data.delete(); return; end
      if (mdl_rs < 0) return;
      mdl_data.push_back(b);
      hi   = mdl_rs / 16;
      ch   = mdl_rs % 16;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      if (mdl_data.size() < need) return;
      t = fall + LAT;
      case (hi)
         8:  emit(2, mdl_data[0], mdl_data[1], ch, t);
         9:  emit((mdl_data[1] != 0) ? 1 : 2, mdl_data[0], mdl_data[1], ch, t);
         10: emit(3, mdl_data[0], mdl_data[1], ch, t);
         13: emit(4, 0, mdl_data[0], ch, t);
         default: ;
      endcase
      mdl_data.delete();
   endtask

   // Caller is at a falling clock edge; returns at a falling clock edge.
   task automatic send_raw(input logic [7:0] b, input bit stop_ok, output longint fall);
      fall = cyc;
      midi_in = 1'b0;
      repeat (CPB) @(negedge clk32);
      for (int i = 0; i < 8; i++) begin
         midi_in = b[i];
         repeat (CPB) @(negedge clk32);
      end
      midi_in = stop_ok;
      repeat (CPB) @(negedge clk32);
      if (!stop_ok) begin
         repeat (CPB) @(negedge clk32);
         midi_in = 1'b1;
         repeat (2 * CPB) @(negedge clk32);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      longint f;
      send_raw(b, 1'b1, f);
      model_byte(int'(b), f);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk32);
   endtask

   task automatic hold_chk(input string tag);
      chk($sformatf("%s_hold_note", tag), longint'(note_interface), last_note);
      chk($sformatf("%s_hold_vel", tag), longint'(velocity), last_vel);
      chk($sformatf("%s_hold_ch", tag), longint'(channel), last_ch);
   endtask

   task automatic cmp_model(input string tag);
      int n;
      chk($sformatf("%s_event_count", tag), act_q.size(), mdl_q.size());
      n = (act_q.size() < mdl_q.size()) ? act_q.size() : mdl_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_ev%0d_kind", tag, i), act_q[i].kind, mdl_q[i].kind);
         chk($sformatf("%s_ev%0d_note", tag, i), act_q[i].note, mdl_q[i].note);
         chk($sformatf("%s_ev%0d_vel", tag, i), act_q[i].vel, mdl_q[i].vel);
         chk($sformatf("%s_ev%0d_ch", tag, i), act_q[i].ch, mdl_q[i].ch);
         lat_chk($sformatf("%s_ev%0d_latency", tag, i), act_q[i].cyc, mdl_q[i].cyc);
      end
      act_q.delete();
      mdl_q.delete();
   endtask

   task automatic cmp_vec(input int idx, input vec_t v);
      int n;
      int ek, en, ev, ec;
      chk($sformatf("vec%0d_event_count", idx), act_q.size(), v.ne);
      n = (act_q.size() < v.ne) ? act_q.size() : v.ne;
      for (int i = 0; i < n; i++) begin
         ek = (i == 0) ? v.k0 : v.k1;
         en = (i == 0) ? v.n0 : v.n1;
         ev = (i == 0) ? v.v0 : v.v1;
         ec = (i == 0) ? v.c0 : v.c1;
         chk($sformatf("vec%0d_ev%0d_kind", idx, i), act_q[i].kind, ek);
         chk($sformatf("vec%0d_ev%0d_note", idx, i), act_q[i].note, en);
         chk($sformatf("vec%0d_ev%0d_vel", idx, i), act_q[i].vel, ev);
         chk($sformatf("vec%0d_ev%0d_ch", idx, i), act_q[i].ch, ec);
         if (i < mdl_q.size())
            lat_chk($sformatf("vec%0d_ev%0d_latency", idx, i), act_q[i].cyc, mdl_q[i].cyc);
      end
      act_q.delete();
      mdl_q.delete();
   endtask

   task automatic add_vec(input int n, input logic [47:0] bytes, input int ne,
                          input int k0, input int n0, input int v0, input int c0,
                          input int k1, input int n1, input int v1, input int c1);
      vec_t v;
      v.n = n; v.bytes = bytes; v.ne = ne;
      v.k0 = k0; v.n0 = n0; v.v0 = v0; v.c0 = c0;
      v.k1 = k1; v.n1 = n1; v.v1 = v1; v.c1 = c1;
      vecs.push_back(v);
   endtask

   initial begin
      vec_t        v;
      logic [47:0] bb;
      longint      dummy;
      int          fe_before;
      int          r;
      logic [7:0]  b;

      fork
         forever @(posedge clk32) cyc++;
         forever begin
            @(negedge clk32);
            strb = {note_channelpress, note_keypress, note_released, note_pressed};
            if (strb != 4'b0) begin
               mon_e.kind = strb[0] ? 1 : strb[1] ? 2 : strb[2] ? 3 : 4;
               mon_e.note = int'(note_interface);
               mon_e.vel  = int'(velocity);
               mon_e.ch   = int'(channel);
               mon_e.cyc  = cyc;
               chk("strobe_onehot_single_cycle",
                   longint'(($countones(strb) == 1) && ((strb & prev_strb) == 4'b0)), 1);
               act_q.push_back(mon_e);
            end
            if (framing_err) begin
               fe_cnt++;
               chk("framing_err_width", longint'(prev_fe), 0);
            end
            prev_strb = strb;
            prev_fe   = framing_err;
         end
      join_none

      add_vec(3, 48'h903C64000000, 1, 1, 'h3C, 'h64, 0, 0, 0, 0, 0);
      add_vec(5, 48'h934050420000, 2, 1, 'h40, 'h50, 3, 2, 'h42, 'h00, 3);
      add_vec(4, 48'h853CF87F0000, 1, 2, 'h3C, 'h7F, 5, 0, 0, 0, 0);
      add_vec(2, 48'hD22200000000, 1, 4, 'h00, 'h22, 2, 0, 0, 0, 0);
      add_vec(5, 48'hB0077FC10500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_vec(3, 48'hA13011000000, 1, 3, 'h30, 'h11, 1, 0, 0, 0, 0);
      add_vec(3, 48'hE30102000000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_vec(5, 48'hF01234F75500, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add_vec(3, 48'h9F7F7F000000, 1, 1, 'h7F, 'h7F, 15, 0, 0, 0, 0);

      // Reset state
      idle(5);
      chk("reset_strobes", longint'({note_pressed, note_released, note_keypress, note_channelpress}), 0);
      chk("reset_note", longint'(note_interface), 0);
      chk("reset_vel", longint'(velocity), 0);
      chk("reset_ch", longint'(channel), 0);
      chk("reset_fe", longint'(framing_err), 0);
      rst_n = 1'b1;
      idle(8);
      hold_chk("post_reset");

      // Table vectors
      foreach (vecs[i]) begin
         v  = vecs[i];
         bb = v.bytes;
         for (int j = 0; j < v.n; j++) send_byte(bb[47 - 8 * j -: 8]);
         idle(2 * CPB);
         cmp_vec(i, v);
         hold_chk($sformatf("vec%0d", i));
         $display("vec %0d: %0d bytes, %0d events expected", i, v.n, v.ne);
      end

      // Framing error mid-message: data count cleared, running status kept
      fe_before = fe_cnt;
      send_byte(8'h93);
      send_byte(8'h40);
      send_raw(8'h90, 1'b0, dummy);
      mdl_data.delete();
      chk("framing_err_count", fe_cnt - fe_before, 1);
      chk("framing_no_event", act_q.size(), 0);
      send_byte(8'h41);
      send_byte(8'h22);
      idle(2 * CPB);
      cmp_model("after_framing_rs");
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'h64);
      idle(2 * CPB);
      cmp_model("after_framing_new");
      hold_chk("after_framing");
      $display("framing sequence done");

      // Short low glitch on the idle line
      fe_before = fe_cnt;
      midi_in = 1'b0;
      idle(6);
      midi_in = 1'b1;
      idle(4 * CPB);
      chk("glitch_no_fe", fe_cnt - fe_before, 0);
      chk("glitch_no_event", act_q.size(), 0);
      send_byte(8'hD2);
      send_byte(8'h22);
      idle(2 * CPB);
      cmp_model("after_glitch");
      $display("glitch sequence done");

      // Reset in the middle of a message and a byte
      send_byte(8'h93);
      send_byte(8'h40);
      fork
         send_raw(8'h90, 1'b1, dummy);
         begin
            idle(3 * CPB);
            rst_n = 1'b0;
         end
      join
      idle(CPB);
      chk("midreset_note", longint'(note_interface), 0);
      chk("midreset_vel", longint'(velocity), 0);
      chk("midreset_ch", longint'(channel), 0);
      chk("midreset_event", act_q.size(), 0);
      mdl_rs = -1;
      mdl_data.delete();
      mdl_q.delete();
      last_note = 0; last_vel = 0; last_ch = 0;
      rst_n = 1'b1;
      idle(8);
      send_byte(8'h3C);
      send_byte(8'h40);
      send_byte(8'h80);
      send_byte(8'h3C);
      send_byte(8'h40);
      idle(2 * CPB);
      cmp_model("after_midreset");
      hold_chk("after_midreset");
      $display("mid-message reset sequence done");

      // Random byte streams against the model
      for (int round = 0; round < 3; round++) begin
         send_byte(8'(32'h80 + $urandom_range(0, 111)));
         for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      b = 8'($urandom_range(8'h80, 8'hEF));
            else if (r < 25) b = 8'($urandom_range(8'hF0, 8'hF7));
            else if (r < 35) b = 8'($urandom_range(8'hF8, 8'hFF));
            else             b = 8'($urandom_range(0, 8'h7F));
            send_byte(b);
         end
         idle(2 * CPB);
         $display("random round %0d: %0d events expected", round, mdl_q.size());
         cmp_model($sformatf("rand%0d", round));
         hold_chk($sformatf("rand%0d", round));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
